// File: rtl/shift_unit_arbiter.sv
// Two-port round-robin front end for a shared SRL/SRA shifter.
// Operands are registered before the shifter, and results are registered before they return to the owning port.
module shift_unit_arbiter #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_0,
    input  logic              req_valid_1,
    output logic              req_ready_0,
    output logic              req_ready_1,
    input  logic [DATA_W-1:0] req_a_0,
    input  logic [DATA_W-1:0] req_a_1,
    input  logic [DATA_W-1:0] req_b_0,
    input  logic [DATA_W-1:0] req_b_1,
    input  logic              req_sel_0,
    input  logic              req_sel_1,
    output logic              rsp_valid_0,
    output logic              rsp_valid_1,
    input  logic              rsp_ready_0,
    input  logic              rsp_ready_1,
    output logic [DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0] sh_a,
    output logic [DATA_W-1:0] sh_b,
    output logic              sh_sel,
    input  logic [DATA_W-1:0] sh_result,
    output logic [CNT_W-1:0]  grant_cnt_0,
    output logic [CNT_W-1:0]  grant_cnt_1
);

    logic               s1_v_q, s1_v_d;
    logic               s1_own_q, s1_own_d;
    logic [DATA_W-1:0]  s1_a_q, s1_a_d;
    logic [SHAMT_W-1:0] s1_b_q, s1_b_d;
    logic               s1_sel_q, s1_sel_d;
    logic               s2_v_q, s2_v_d;
    logic               s2_own_q, s2_own_d;
    logic [DATA_W-1:0]  s2_data_q, s2_data_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_0_q, cnt_0_d;
    logic [CNT_W-1:0]   cnt_1_q, cnt_1_d;

    logic s2_free, s1_move, s1_free, gnt, accept;

    // Only the low shift-amount bits of B reach the shifter.
    logic unused_b_hi;
    assign unused_b_hi = ^{req_b_0[DATA_W-1:SHAMT_W], req_b_1[DATA_W-1:SHAMT_W]};

    always_comb begin
        s2_free = !s2_v_q || (s2_own_q ? rsp_ready_1 : rsp_ready_0);
        s1_move = s1_v_q && s2_free;
        s1_free = !s1_v_q || s1_move;
        gnt     = (req_valid_0 && req_valid_1) ? rr_ptr_q : req_valid_1;
        // Ready is forced low while reset is held, even though s1 reads as free.
        accept  = rst_n && s1_free && (req_valid_0 || req_valid_1);

        req_ready_0 = accept && !gnt;
        req_ready_1 = accept && gnt;

        s1_v_d    = s1_v_q;
        s1_own_d  = s1_own_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_sel_d  = s1_sel_q;
        s2_v_d    = s2_v_q;
        s2_own_d  = s2_own_q;
        s2_data_d = s2_data_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_0_d   = cnt_0_q;
        cnt_1_d   = cnt_1_q;

        if (s1_move) begin
            s2_v_d    = 1'b1;
            s2_own_d  = s1_own_q;
            s2_data_d = sh_result;
        end else if (s2_free) begin
            s2_v_d = 1'b0;
        end

        if (accept) begin
            s1_v_d   = 1'b1;
            s1_own_d = gnt;
            s1_a_d   = gnt ? req_a_1 : req_a_0;
            s1_b_d   = gnt ? req_b_1[SHAMT_W-1:0] : req_b_0[SHAMT_W-1:0];
            s1_sel_d = gnt ? req_sel_1 : req_sel_0;
            rr_ptr_d = !gnt;
            if (!gnt && cnt_0_q != '1) cnt_0_d = cnt_0_q + CNT_W'(1);
            if (gnt && cnt_1_q != '1) cnt_1_d = cnt_1_q + CNT_W'(1);
        end else if (s1_move) begin
            s1_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_own_q  <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_sel_q  <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_own_q  <= 1'b0;
            s2_data_q <= '0;
            rr_ptr_q  <= 1'b0;
            cnt_0_q   <= '0;
            cnt_1_q   <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_own_q  <= s1_own_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_sel_q  <= s1_sel_d;
            s2_v_q    <= s2_v_d;
            s2_own_q  <= s2_own_d;
            s2_data_q <= s2_data_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_0_q   <= cnt_0_d;
            cnt_1_q   <= cnt_1_d;
        end
    end

    assign rsp_valid_0 = s2_v_q && !s2_own_q;
    assign rsp_valid_1 = s2_v_q && s2_own_q;
    assign rsp_data    = s2_data_q;
    assign sh_a        = s1_a_q;
    assign sh_b        = {{(DATA_W-SHAMT_W){1'b0}}, s1_b_q};
    assign sh_sel      = s1_sel_q;
    assign grant_cnt_0 = cnt_0_q;
    assign grant_cnt_1 = cnt_1_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Bench for shift_unit_arbiter: queue-based reference model compared every cycle, directed literal cases, random traffic.
module tb_shift_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_0, req_valid_1, req_ready_0, req_ready_1;
    logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
    logic        req_sel_0, req_sel_1;
    logic        rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
    logic [31:0] rsp_data, sh_a, sh_b, sh_result, srl_w, sra_w;
    logic        sh_sel;
    logic [15:0] grant_cnt_0, grant_cnt_1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    shift_unit_arbiter #(.DATA_W(32), .SHAMT_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .req_sel_0(req_sel_0), .req_sel_1(req_sel_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_data(rsp_data), .sh_a(sh_a), .sh_b(sh_b), .sh_sel(sh_sel),
        .sh_result(sh_result),
        .grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1)
    );

    // External shared shifter.
    assign srl_w     = sh_a >> sh_b[4:0];
    assign sra_w     = $signed(sh_a) >>> sh_b[4:0];
    assign sh_result = sh_sel ? sra_w : srl_w;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Shift computed as division by a power of two (floor for the arithmetic case).
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b, input logic sel);
        int     sh;
        longint p, v;
        sh = int'(b % 32);
        p  = longint'(1) << sh;
        if (!sel) begin
            v = longint'(a) / p;
        end else begin
            v = longint'($signed(a));
            if (v >= 0) v = v / p;
            else        v = -((-v + p - 1) / p);
        end
        return v[31:0];
    endfunction

    typedef struct {
        logic        own;
        logic [31:0] a;
        logic [4:0]  sh;
        logic        sel;
        logic [31:0] res;
        bit          pres;
    } ent_t;

    ent_t q[$];
    int   m_cnt0, m_cnt1;
    bit   m_rr;

    // Model: up to two in-flight ops in order; 'pres' marks the op currently offered as a response.
    function automatic void calc(output bit r0, output bit r1, output bit pop);
        bit has_pres, s2_free, s1_free, g;
        int n_unp;
        has_pres = (q.size() > 0) && q[0].pres;
        n_unp    = q.size() - (has_pres ? 1 : 0);
        pop      = has_pres && (q[0].own ? rsp_ready_1 : rsp_ready_0);
        s2_free  = !has_pres || pop;
        s1_free  = (n_unp == 0) || s2_free;
        g        = (req_valid_0 && req_valid_1) ? m_rr : req_valid_1;
        r0       = rst_n && s1_free && req_valid_0 && !g;
        r1       = rst_n && s1_free && req_valid_1 && g;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit   r0, r1, pop;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            m_cnt0 = 0;
            m_cnt1 = 0;
            m_rr   = 1'b0;
        end else begin
            calc(r0, r1, pop);
            if (pop) void'(q.pop_front());
            if (q.size() > 0 && !q[0].pres) q[0].pres = 1'b1;
            if (r0 || r1) begin
                e.own  = r1;
                e.a    = r1 ? req_a_1 : req_a_0;
                e.sh   = r1 ? req_b_1[4:0] : req_b_0[4:0];
                e.sel  = r1 ? req_sel_1 : req_sel_0;
                e.res  = ref_shift(e.a, r1 ? req_b_1 : req_b_0, e.sel);
                e.pres = 1'b0;
                q.push_back(e);
                m_rr = !r1;
                if (r0 && m_cnt0 < 65535) m_cnt0++;
                if (r1 && m_cnt1 < 65535) m_cnt1++;
            end
        end
    end

    always @(negedge clk) begin
        bit r0, r1, pop, ev0, ev1;
        calc(r0, r1, pop);
        ev0 = (q.size() > 0) && q[0].pres && !q[0].own;
        ev1 = (q.size() > 0) && q[0].pres && q[0].own;
        chk("req_ready_0", req_ready_0, r0);
        chk("req_ready_1", req_ready_1, r1);
        chk("rsp_valid_0", rsp_valid_0, ev0);
        chk("rsp_valid_1", rsp_valid_1, ev1);
        if (ev0 || ev1) chk("rsp_data", rsp_data, q[0].res);
        chk("grant_cnt_0", grant_cnt_0, m_cnt0);
        chk("grant_cnt_1", grant_cnt_1, m_cnt1);
        if (q.size() > 0 && !q[q.size()-1].pres) begin
            chk("sh_a", sh_a, q[q.size()-1].a);
            chk("sh_b", sh_b, {27'b0, q[q.size()-1].sh});
            chk("sh_sel", sh_sel, q[q.size()-1].sel);
        end
        if (!rst_n) begin
            chk("rst_rsp_data", rsp_data, 32'h0);
            chk("rst_sh_a", sh_a, 32'h0);
            chk("rst_sh_b", sh_b, 32'h0);
            chk("rst_sh_sel", sh_sel, 1'b0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit p, input logic [31:0] a, input logic [31:0] b, input logic sel);
        if (p) begin req_valid_1 = 1'b1; req_a_1 = a; req_b_1 = b; req_sel_1 = sel; end
        else   begin req_valid_0 = 1'b1; req_a_0 = a; req_b_0 = b; req_sel_0 = sel; end
    endtask

    task automatic do_op(input bit p, input logic [31:0] a, input logic [31:0] b, input logic sel,
                         input logic [31:0] exp);
        int n, lat;
        drive(p, a, b, sel);
        @(negedge clk);
        n = 0;
        while (!(p ? req_ready_1 : req_ready_0) && n < 20) begin @(negedge clk); n++; end
        chk("op_accept_bound", n < 20, 1'b1);
        tick;
        if (p) req_valid_1 = 1'b0; else req_valid_0 = 1'b0;
        @(negedge clk);
        lat = 1;
        while (!(p ? rsp_valid_1 : rsp_valid_0) && lat < 20) begin @(negedge clk); lat++; end
        chk("op_latency", lat, 2);
        chk("op_rsp_data", rsp_data, exp);
        tick;
    endtask

    logic [31:0] tab_a [4] = '{32'hF0F0F0F0, 32'h80000001, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] tab_b [4] = '{32'h4, 32'h1, 32'h1F, 32'h3F};
    logic        tab_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] tab_r [4] = '{32'h0F0F0F0F, 32'hC0000000, 32'h00000001, 32'h00000000};
    logic [31:0] stall_a [3] = '{32'h00000100, 32'h00001000, 32'h00010000};
    logic [31:0] stall_r [3] = '{32'h00000001, 32'h00000010, 32'h00000100};

    initial begin
        int  gi, ri, g0, g1, acc, n, seen;
        bit  got_own [4];
        logic [31:0] got_dat [4];

        rst_n = 1'b0;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        req_a_0 = '0; req_a_1 = '0; req_b_0 = '0; req_b_1 = '0;
        req_sel_0 = 1'b0; req_sel_1 = 1'b0;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        repeat (2) tick;
        chk("reset_ready_0", req_ready_0, 1'b0);
        chk("reset_ready_1", req_ready_1, 1'b0);
        chk("reset_rsp_valid", {rsp_valid_1, rsp_valid_0}, 2'b00);
        chk("reset_cnt", {grant_cnt_1, grant_cnt_0}, 32'h0);
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        rst_n = 1'b1;
        tick;

        // Single-port operations with literal results.
        do_op(1'b0, 32'h80000000, 32'h4, 1'b0, 32'h08000000);
        chk("p0_grant_cnt", grant_cnt_0, 16'd1);
        do_op(1'b1, 32'h80000000, 32'h4, 1'b1, 32'hF8000000);
        do_op(1'b1, 32'hF0000000, 32'h25, 1'b1, 32'hFF800000);
        do_op(1'b1, 32'h12345678, 32'h20, 1'b1, 32'h12345678);
        chk("p1_grant_cnt", grant_cnt_1, 16'd3);

        // Both ports contending: grants alternate starting with port 0.
        g0 = 0; g1 = 0; gi = 0; ri = 0;
        drive(1'b0, tab_a[0], tab_b[0], tab_s[0]);
        drive(1'b1, tab_a[1], tab_b[1], tab_s[1]);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (gi < 4) chk("rr_grant", {req_ready_1, req_ready_0}, (gi % 2) ? 2'b10 : 2'b01);
            if ((rsp_valid_0 || rsp_valid_1) && ri < 4) begin
                got_own[ri] = rsp_valid_1;
                got_dat[ri] = rsp_data;
                ri++;
            end
            @(posedge clk);
            #1;
            if (gi < 4) begin
                gi++;
                if (gi == 4) begin
                    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
                end else if (gi == 2) begin
                    drive(1'b0, tab_a[2], tab_b[2], tab_s[2]);
                end else if (gi == 3) begin
                    drive(1'b1, tab_a[3], tab_b[3], tab_s[3]);
                end
            end
        end
        chk("rr_rsp_count", ri, 4);
        for (int k = 0; k < 4; k++) begin
            chk("rr_rsp_owner", got_own[k], k % 2);
            chk("rr_rsp_data", got_dat[k], tab_r[k]);
        end
        chk("rr_cnt_0", grant_cnt_0, 16'd3);
        chk("rr_cnt_1", grant_cnt_1, 16'd5);

        // Back-pressure on port 0: two ops fill the pipe, the third waits.
        rsp_ready_0 = 1'b0;
        acc = 0;
        drive(1'b0, stall_a[0], 32'h8, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (req_ready_0) acc++;
            if (rsp_valid_0) chk("stall_data_stable", rsp_data, stall_r[0]);
            @(posedge clk);
            #1;
            if (acc < 3) req_a_0 = stall_a[acc];
        end
        chk("stall_accepted", acc, 2);
        chk("stall_ready_low", req_ready_0, 1'b0);
        chk("stall_rsp_valid", rsp_valid_0, 1'b1);
        rsp_ready_0 = 1'b1;
        @(negedge clk);
        chk("release_accept", req_ready_0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("drain_valid", rsp_valid_0, 1'b1);
            chk("drain_data", rsp_data, stall_r[k]);
            @(posedge clk);
            #1;
            req_valid_0 = 1'b0;
            @(negedge clk);
        end
        chk("drain_empty", rsp_valid_0, 1'b0);

        // Reset with both stages occupied.
        tick;
        rsp_ready_0 = 1'b0;
        drive(1'b0, 32'hAAAA0000, 32'h4, 1'b0);
        tick;
        req_a_0 = 32'h5555_0000;
        tick;
        req_valid_0 = 1'b0;
        chk("pre_reset_rsp_valid", rsp_valid_0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_rsp_valid", {rsp_valid_1, rsp_valid_0}, 2'b00);
        chk("mid_reset_cnt", {grant_cnt_1, grant_cnt_0}, 32'h0);
        repeat (2) tick;
        rst_n = 1'b1;
        rsp_ready_0 = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid_0 || rsp_valid_1) seen++;
        end
        chk("post_reset_no_rsp", seen, 0);

        // Random traffic against the model.
        tick;
        for (int c = 0; c < 3000; c++) begin
            req_valid_0 = ($urandom_range(9) < 6);
            req_valid_1 = ($urandom_range(9) < 6);
            req_a_0 = $urandom; req_a_1 = $urandom;
            req_b_0 = $urandom; req_b_1 = $urandom;
            req_sel_0 = $urandom_range(1); req_sel_1 = $urandom_range(1);
            rsp_ready_0 = ($urandom_range(9) < 7);
            rsp_ready_1 = ($urandom_range(9) < 7);
            tick;
        end

        // Saturate port 0's counter.
        req_valid_1 = 1'b0;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        drive(1'b0, 32'h1, 32'h0, 1'b0);
        n = 0;
        while (m_cnt0 < 65535 && n < 70000) begin tick; n++; end
        chk("sat_bound", n < 70000, 1'b1);
        chk("sat_reach", grant_cnt_0, 16'hFFFF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("sat_still_granted", req_ready_0, 1'b1);
            tick;
        end
        chk("sat_hold", grant_cnt_0, 16'hFFFF);
        req_valid_0 = 1'b0;
        repeat (4) tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/shift_unit_arbiter.md
Name: shift_unit_arbiter

Overview:
- Shares one SRL/SRA shift datapath between two requesters: port 0 is the ALU issue path and port 1 is the secondary or multi-cycle path.
- Round-robin arbitration at the request side, a registered operand stage that drives the shared shifter, and a registered response stage routed back to the owning port.
- Valid/ready handshake on both sides; throughput is one shift per cycle.
- Sits between the issue logic and the shift datapath in the execute stage.

Parameters:
- DATA_W, 32, operand/result width; fixed at 32 for RV32.
- SHAMT_W, 5, shift-amount bits taken from B[SHAMT_W-1:0].
- CNT_W, 16, width of the per-port grant counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_0, req_valid_1  in  1  request valid, per port
- req_ready_0, req_ready_1  out  1  request accepted this cycle, per port
- req_a_0, req_a_1  in  DATA_W  operand to shift
- req_b_0, req_b_1  in  DATA_W  shift amount source; only [SHAMT_W-1:0] used
- req_sel_0, req_sel_1  in  1  0 = logical (SRL), 1 = arithmetic (SRA)
- rsp_valid_0, rsp_valid_1  out  1  result valid for that port
- rsp_ready_0, rsp_ready_1  in  1  port consumes result
- rsp_data  out  DATA_W  result, shared bus; qualified by rsp_valid_x
- sh_a  out  DATA_W  to shared shifter A
- sh_b  out  DATA_W  to shared shifter B; upper bits driven 0
- sh_sel  out  1  to shared shifter Sel
- sh_result  in  DATA_W  shifter result (combinational, same cycle)
- grant_cnt_0, grant_cnt_1  out  CNT_W  accepted-request counters, saturating

Behaviour:
- Reset (async assert, sync deassert use): s1_v = s2_v = 0, rr_ptr = 0, all counters 0, req_ready_x = 0, rsp_valid_x = 0, rsp_data = 0, sh_a = sh_b = 0, sh_sel = 0.
- Reset mid-operation: in-flight ops are dropped silently and no response is issued.
- Stage 1 (operand register) holds s1_v, s1_own, s1_a, s1_b[SHAMT_W-1:0], s1_sel.
  - sh_a = s1_a, sh_b = zero-extended s1_b, sh_sel = s1_sel.
- Stage 2 (response register) holds s2_v, s2_own, s2_data.
  - rsp_valid_x = s2_v && (s2_own == x); rsp_data = s2_data.
- Advance rules:
  - s2_free = !s2_v || rsp_ready_[s2_own].
  - s1 moves to s2 when s1_v && s2_free; sh_result is captured into s2_data.
  - s1_free = !s1_v || s1 moves.
  - If s1 is valid and s2 is not free, s1 holds and sh_* stay stable.
- Arbitration (combinational, from req_valid and rr_ptr):
  - Only one valid: that port is granted.
  - Both valid: the port equal to rr_ptr is granted.
  - req_ready_g = s1_free for the granted port g; the other port's ready is 0.
- Handshake on port g (req_valid_g && req_ready_g):
  - s1 loads g's operands and s1_own = g.
  - rr_ptr <= ~g.
  - grant_cnt_g increments, saturating at all-ones.
- Latency: a request accepted at edge N gives rsp_valid at edge N+2, assuming no stall.
- Back-to-back: a full pipeline with both rsp_ready high accepts one request every cycle.
- Response-side rules:
  - rsp_valid and rsp_data hold stable until rsp_ready of the owning port.
  - The non-owner's rsp_ready is ignored.
- Shift amount: B bits above SHAMT_W are ignored (B = 0x25 behaves as shamt 5). Shamt 0 returns A unchanged.
- Requesters rules:
  - May drop req_valid before acceptance (no commitment).
  - Payload is sampled only at the handshake edge.
- Simultaneous events in the same cycle are legal: s2 drains, s1 advances, and a new request is accepted.

Test Plan:
- Port 0 only: A=0x80000000, B=4, sel=0 → rsp_valid_0 two cycles after accept, rsp_data=0x08000000; grant_cnt_0=1.
- Port 1 only: A=0x80000000, B=4, sel=1 → rsp_valid_1, rsp_data=0xF8000000; then B=0x25, A=0xF0000000, sel=1 → 0xFF800000.
- Both valid for 4 cycles, rr_ptr=0 at start, rsp_ready high → grants 0,1,0,1; responses return in the same order with the correct owner flags; grant_cnt_0 = grant_cnt_1 = 2.
- Hold rsp_ready_0=0 for 5 cycles with 3 port-0 requests → two accepted (s1, s2 full), third req_ready_0=0; rsp_data stable. Release → drains in order at 1/cycle.
- Assert rst_n=0 mid-pipeline with s1 and s2 valid → all rsp_valid_x=0 immediately, counters=0, no response after release.
- Force 0xFFFF grants on port 0 → grant_cnt_0 stays 0xFFFF on the next grant.
